// File: rtl/core_pkg.sv
// Shared pipeline definitions: load/store funct3 encodings, MEM FSM states,
// access-size decode and the data-memory request bundle.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} acc_size_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

  // Unlisted encodings fall back to a full word access.
  function automatic acc_size_e acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: acc_size = SZ_B;
      F3_H, F3_HU: acc_size = SZ_H;
      default:     acc_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: picks the addressed byte/halfword out of the read
// word and sign- or zero-extends it according to funct3.
module mem_load_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data-memory handshake for loads/stores,
// detects misalignment and bus timeouts, and registers results into MEM/WB.
module mem_stage
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_MEM_enable_out,
  input  logic [31:0] EX_MEM_PC,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic [2:0]  EX_MEM_Funct3,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemToReg,
  input  logic        EX_MEM_RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [31:0] MEM_WB_ReadData,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_MemToReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_enable_out,
  output logic        mem_stall,
  output logic        mem_misaligned,
  output logic        mem_bus_error
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  mem_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  acc_size_e        size;
  dmem_req_t        dreq;
  logic             access, misaligned, abort, complete;
  logic [31:0]      load_data;

  assign size       = acc_size(EX_MEM_Funct3);
  assign access     = EX_MEM_enable_out & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign misaligned = access & (((size == SZ_H) & EX_MEM_ALUResult[0]) |
                                ((size == SZ_W) & (|EX_MEM_ALUResult[1:0])));
  // Ready on the final wait cycle still completes normally.
  assign abort      = (TIMEOUT_CYCLES != 0) && (state == WAIT) &&
                      (cnt == CNT_LAST) && !dmem_ready;

  always_comb begin
    dreq       = '0;
    dreq.req   = access & ~misaligned & ~abort & ~reset;
    dreq.we    = dreq.req & EX_MEM_MemWrite;
    dreq.addr  = {EX_MEM_ALUResult[31:2], 2'b00};
    dreq.wdata = EX_MEM_WriteData;
    case (size)
      SZ_B: begin
        dreq.be    = 4'b0001 << EX_MEM_ALUResult[1:0];
        dreq.wdata = {4{EX_MEM_WriteData[7:0]}};
      end
      SZ_H: begin
        dreq.be    = EX_MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
        dreq.wdata = {2{EX_MEM_WriteData[15:0]}};
      end
      default: dreq.be = 4'b1111;
    endcase
    if (!dreq.req) dreq.be = 4'b0000;
  end

  assign dmem_req   = dreq.req;
  assign dmem_we    = dreq.we;
  assign dmem_addr  = dreq.addr;
  assign dmem_be    = dreq.be;
  assign dmem_wdata = dreq.wdata;
  assign mem_stall  = dreq.req & ~dmem_ready;

  assign complete = EX_MEM_enable_out &
                    (~access | (dreq.req & dmem_ready) | misaligned | abort);

  mem_load_align u_align (
    .funct3    (EX_MEM_Funct3),
    .addr_lo   (EX_MEM_ALUResult[1:0]),
    .rdata     (dmem_rdata),
    .load_data (load_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (dreq.req && !dmem_ready) begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: if (!dreq.req || dmem_ready) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt   = cnt + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      MEM_WB_PC         <= '0;
      MEM_WB_ALUResult  <= '0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_Rd         <= '0;
      MEM_WB_MemToReg   <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_enable_out <= 1'b0;
      mem_misaligned    <= 1'b0;
      mem_bus_error     <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      MEM_WB_enable_out <= complete;
      mem_misaligned    <= misaligned;
      mem_bus_error     <= abort;
      // Without a completing edge the stage emits a bubble and holds payload.
      if (complete) begin
        MEM_WB_PC        <= EX_MEM_PC;
        MEM_WB_ALUResult <= EX_MEM_ALUResult;
        MEM_WB_Rd        <= EX_MEM_Rd;
        MEM_WB_MemToReg  <= EX_MEM_MemToReg;
        MEM_WB_RegWrite  <= EX_MEM_RegWrite & ~misaligned & ~abort;
        MEM_WB_ReadData  <= (access & ~EX_MEM_MemWrite & ~misaligned & ~abort)
                            ? load_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// against a byte-lane arithmetic reference model.
module tb_mem_stage;

  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic        clk, reset;
  logic        EX_MEM_enable_out;
  logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [4:0]  EX_MEM_Rd;
  logic [2:0]  EX_MEM_Funct3;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_MemToReg, MEM_WB_RegWrite, MEM_WB_enable_out;
  logic        mem_stall, mem_misaligned, mem_bus_error;

  int checks = 0;
  int failures = 0;

  logic [31:0] e_pc, e_alu, e_rdata;
  logic [4:0]  e_rd;
  logic        e_m2r, e_rw;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .EX_MEM_enable_out(EX_MEM_enable_out), .EX_MEM_PC(EX_MEM_PC),
    .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_Funct3(EX_MEM_Funct3),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ALUResult(MEM_WB_ALUResult),
    .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_Rd(MEM_WB_Rd),
    .MEM_WB_MemToReg(MEM_WB_MemToReg), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_enable_out(MEM_WB_enable_out),
    .mem_stall(mem_stall), .mem_misaligned(mem_misaligned),
    .mem_bus_error(mem_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input logic xen, input logic xmis, input logic xberr);
    chk("wb_enable", 32'(MEM_WB_enable_out), 32'(xen));
    chk("wb_pc", MEM_WB_PC, e_pc);
    chk("wb_alu", MEM_WB_ALUResult, e_alu);
    chk("wb_rdata", MEM_WB_ReadData, e_rdata);
    chk("wb_rd", 32'(MEM_WB_Rd), 32'(e_rd));
    chk("wb_memtoreg", 32'(MEM_WB_MemToReg), 32'(e_m2r));
    chk("wb_regwrite", 32'(MEM_WB_RegWrite), 32'(e_rw));
    chk("misaligned", 32'(mem_misaligned), 32'(xmis));
    chk("bus_error", 32'(mem_bus_error), 32'(xberr));
  endtask

  // Entered and left at a falling edge. rdly = cycles of no-ready before ready.
  task automatic run_instr(input bit en, input logic [2:0] f3, input bit mr, input bit mw,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           input logic [31:0] rdat, input int rdly,
                           input logic [31:0] pc, input logic [4:0] rd,
                           input bit m2r, input bit rw, output int nstall);
    int nb, off, k;
    bit is_b, is_h, sgn, acc, mis, ab, xreq, done;
    logic [31:0] mask, xwd, xrd;
    logic [3:0] xbe;
    is_b = (f3 == 3'd0) || (f3 == 3'd4);
    is_h = (f3 == 3'd1) || (f3 == 3'd5);
    sgn  = (f3 == 3'd0) || (f3 == 3'd1);
    nb   = is_b ? 1 : (is_h ? 2 : 4);
    off  = int'(addr[1:0]) - (int'(addr[1:0]) % nb);
    acc  = en && (mr || mw);
    mis  = acc && (int'(addr[1:0]) % nb != 0);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    xbe  = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) xwd[8*i +: 8] = wdat[8*(i % nb) +: 8];
    xrd  = (rdat >> (8 * off)) & mask;
    if (sgn && xrd[8*nb-1]) xrd = xrd | ~mask;

    EX_MEM_enable_out = en; EX_MEM_PC = pc; EX_MEM_ALUResult = addr;
    EX_MEM_WriteData = wdat; EX_MEM_Rd = rd; EX_MEM_Funct3 = f3;
    EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw;
    EX_MEM_MemToReg = m2r; EX_MEM_RegWrite = rw;
    nstall = 0; k = 0; done = 0;
    while (!done) begin
      dmem_ready = (rdly == k);
      dmem_rdata = dmem_ready ? rdat : $urandom;
      #1;
      ab   = acc && !mis && (k == TO) && (rdly != k);
      xreq = acc && !mis && !ab;
      chk("dmem_req", 32'(dmem_req), 32'(xreq));
      chk("mem_stall", 32'(mem_stall), 32'(xreq && (rdly != k)));
      if (xreq) begin
        chk("dmem_we", 32'(dmem_we), 32'(mw));
        chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("dmem_be", 32'(dmem_be), 32'(xbe));
        if (mw) chk("dmem_wdata", dmem_wdata, xwd);
      end
      if (mem_stall) nstall++;
      done = !acc || mis || ab || (rdly == k);
      @(posedge clk);
      @(negedge clk);
      if (done && en) begin
        e_pc = pc; e_alu = addr; e_rd = rd; e_m2r = m2r;
        e_rw = rw && !mis && !ab;
        e_rdata = (acc && !mw && !mis && !ab) ? xrd : 32'd0;
      end
      chk_wb(done && en, done && mis, ab);
      k++;
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    int ns;
    logic [2:0] f3_tab [6];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    reset = 1'b1;
    EX_MEM_enable_out = 0; EX_MEM_PC = 0; EX_MEM_ALUResult = 0; EX_MEM_WriteData = 0;
    EX_MEM_Rd = 0; EX_MEM_Funct3 = 0; EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0;
    EX_MEM_MemToReg = 0; EX_MEM_RegWrite = 0; dmem_rdata = 0; dmem_ready = 0;
    e_pc = 0; e_alu = 0; e_rdata = 0; e_rd = 0; e_m2r = 0; e_rw = 0;
    @(negedge clk); @(negedge clk);
    chk_wb(1'b0, 1'b0, 1'b0);
    chk("reset_req", 32'(dmem_req), 32'd0);
    chk("reset_stall", 32'(mem_stall), 32'd0);
    reset = 1'b0;

    // ALU op passes straight through
    run_instr(1, 3'd2, 0, 0, 32'h1234, 0, 0, 0, 32'h100, 5'd5, 0, 1, ns);
    chk("alu_stall_cycles", ns, 0);
    chk("alu_result", MEM_WB_ALUResult, 32'h1234);
    // LB / LBU at byte 3
    run_instr(1, 3'd0, 1, 0, 32'h103, 0, 32'h80FF_00AA, 0, 32'h104, 5'd7, 1, 1, ns);
    chk("lb_data", MEM_WB_ReadData, 32'hFFFF_FF80);
    run_instr(1, 3'd4, 1, 0, 32'h103, 0, 32'h80FF_00AA, 0, 32'h108, 5'd8, 1, 1, ns);
    chk("lbu_data", MEM_WB_ReadData, 32'h0000_0080);
    // SH with 3 wait cycles
    run_instr(1, 3'd1, 0, 1, 32'h202, 32'hDEAD_BEEF, 0, 3, 32'h10C, 5'd0, 0, 0, ns);
    chk("sh_stall_cycles", ns, 3);
    chk("sh_rdata_zero", MEM_WB_ReadData, 32'd0);
    // misaligned LW
    run_instr(1, 3'd2, 1, 0, 32'h101, 0, 32'h5555_5555, 0, 32'h110, 5'd9, 1, 1, ns);
    chk("mis_regwrite", 32'(MEM_WB_RegWrite), 32'd0);
    // timeout, then ready exactly on the timeout edge
    run_instr(1, 3'd2, 1, 0, 32'h300, 0, 32'h1111_2222, NEVER, 32'h114, 5'd10, 1, 1, ns);
    chk("timeout_stall_cycles", ns, TO);
    chk("timeout_regwrite", 32'(MEM_WB_RegWrite), 32'd0);
    run_instr(1, 3'd2, 1, 0, 32'h304, 0, 32'hCAFE_F00D, TO, 32'h118, 5'd11, 1, 1, ns);
    chk("late_ready_stall_cycles", ns, TO);
    chk("late_ready_data", MEM_WB_ReadData, 32'hCAFE_F00D);
    // read+write together behaves as a store
    run_instr(1, 3'd2, 1, 1, 32'h400, 32'h0BAD_CAFE, 32'h7777_7777, 1, 32'h11C, 5'd12, 0, 1, ns);

    // reset during the second WAIT cycle
    EX_MEM_enable_out = 1; EX_MEM_PC = 32'h200; EX_MEM_ALUResult = 32'h500;
    EX_MEM_Funct3 = 3'd2; EX_MEM_MemRead = 1; EX_MEM_MemWrite = 0;
    EX_MEM_Rd = 5'd3; EX_MEM_RegWrite = 1; EX_MEM_MemToReg = 1; dmem_ready = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 chk("pre_reset_req", 32'(dmem_req), 32'd1);
    #1 reset = 1'b1;
    #1 chk("reset_req_drop", 32'(dmem_req), 32'd0);
    chk("reset_stall_drop", 32'(mem_stall), 32'd0);
    e_pc = 0; e_alu = 0; e_rdata = 0; e_rd = 0; e_m2r = 0; e_rw = 0;
    chk_wb(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(1, 3'd2, 1, 0, 32'h500, 0, 32'h1357_9BDF, 1, 32'h200, 5'd3, 1, 1, ns);
    chk("post_reset_data", MEM_WB_ReadData, 32'h1357_9BDF);

    for (int n = 0; n < 60; n++) begin
      bit en, mr, mw;
      int r, op, dly;
      en = ($urandom % 8) != 0;
      op = $urandom % 3;
      mr = (op == 1); mw = (op == 2);
      if ($urandom % 10 == 0) begin mr = 1; mw = 1; end
      r = $urandom % 10;
      dly = (r < 6) ? (r % 3) : ((r < 9) ? int'($urandom_range(3, 8)) : NEVER);
      run_instr(en, f3_tab[$urandom % 6], mr, mw, $urandom, $urandom, $urandom, dly,
                $urandom, 5'($urandom), 1'($urandom), 1'($urandom), ns);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
